// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage pipeline, with saturating event counters
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] i_RS1_D,
    input  logic [REG_ADDR_WIDTH-1:0] i_RS2_D,
    input  logic [REG_ADDR_WIDTH-1:0] i_RS1_E,
    input  logic [REG_ADDR_WIDTH-1:0] i_RS2_E,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rd_E,
    input  logic                      i_RegWrite_E,
    input  logic [1:0]                i_ResultSrc_E,
    input  logic                      i_PCSrc_E,
    input  logic                      i_CntClr,
    output logic                      o_Stall_F,
    output logic                      o_Stall_D,
    output logic                      o_Flush_D,
    output logic                      o_Flush_E,
    output logic [1:0]                o_ForwardA_E,
    output logic [1:0]                o_ForwardB_E,
    output logic [CNT_WIDTH-1:0]      o_StallCnt,
    output logic [CNT_WIDTH-1:0]      o_FlushCnt
);
    logic [REG_ADDR_WIDTH-1:0] rd_m, rd_w;
    logic                      wr_m, wr_w, lw_stall, hit_m_a, hit_w_a, hit_m_b, hit_w_b;

    // shadow of the M/W destination registers; EX/MEM and MEM/WB never stall so no enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_m <= '0;
            wr_m <= 1'b0;
            rd_w <= '0;
            wr_w <= 1'b0;
        end else begin
            rd_m <= i_Rd_E;
            wr_m <= i_RegWrite_E;
            rd_w <= rd_m;
            wr_w <= wr_m;
        end
    end

    // hazard detection and outputs; x0 never matches and reset forces everything idle
    always_comb begin
        hit_m_a      = wr_m && rd_m != '0 && rd_m == i_RS1_E;
        hit_w_a      = wr_w && rd_w != '0 && rd_w == i_RS1_E;
        hit_m_b      = wr_m && rd_m != '0 && rd_m == i_RS2_E;
        hit_w_b      = wr_w && rd_w != '0 && rd_w == i_RS2_E;
        lw_stall     = i_ResultSrc_E == 2'b01 && i_Rd_E != '0 && (i_Rd_E == i_RS1_D || i_Rd_E == i_RS2_D);
        o_Stall_F    = rst && lw_stall && !i_PCSrc_E;
        o_Stall_D    = o_Stall_F;
        o_Flush_D    = rst && i_PCSrc_E;
        o_Flush_E    = rst && (lw_stall || i_PCSrc_E);
        o_ForwardA_E = !rst ? 2'b00 : hit_m_a ? 2'b10 : hit_w_a ? 2'b01 : 2'b00;
        o_ForwardB_E = !rst ? 2'b00 : hit_m_b ? 2'b10 : hit_w_b ? 2'b01 : 2'b00;
    end

    // saturating event counters; clear wins over a same-cycle event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_StallCnt <= '0;
            o_FlushCnt <= '0;
        end else if (i_CntClr) begin
            o_StallCnt <= '0;
            o_FlushCnt <= '0;
        end else begin
            if (o_Stall_D && o_StallCnt != '1) o_StallCnt <= o_StallCnt + 1'b1;
            if (o_Flush_D && o_FlushCnt != '1) o_FlushCnt <= o_FlushCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit (4-bit counters)
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       rw_e, pcs, clr;
    logic [1:0] rs_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;
    logic [15:0] obs;
    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } sb_t;
    sb_t sb[$];

    hazard_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_RS1_D(rs1_d), .i_RS2_D(rs2_d), .i_RS1_E(rs1_e), .i_RS2_E(rs2_e),
        .i_Rd_E(rd_e), .i_RegWrite_E(rw_e), .i_ResultSrc_E(rs_e), .i_PCSrc_E(pcs),
        .i_CntClr(clr),
        .o_Stall_F(stall_f), .o_Stall_D(stall_d), .o_Flush_D(flush_d), .o_Flush_E(flush_e),
        .o_ForwardA_E(fwd_a), .o_ForwardB_E(fwd_b),
        .o_StallCnt(stall_cnt), .o_FlushCnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt, flush_cnt};

    function automatic logic [15:0] ex(input logic sf, sd, fd, fe, input logic [1:0] fa, fb,
                                       input logic [3:0] sc, fc);
        return {sf, sd, fd, fe, fa, fb, sc, fc};
    endfunction

    task automatic drv(input logic [4:0] a_d, b_d, a_e, b_e, d_e, input logic w, input logic [1:0] s,
                       input logic p);
        rs1_d = a_d; rs2_d = b_d; rs1_e = a_e; rs2_e = b_e; rd_e = d_e; rw_e = w; rs_e = s; pcs = p;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [15:0] e);
        sb_t item;
        sb.push_back('{tag, e});
        #1;
        item = sb.pop_front();
        total++;
        assert (obs === item.val) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", item.tag, obs, item.val);
        end
    endtask

    initial begin
        clr = 1'b0;
        drv(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b1);
        #1;
        step("reset_force", ex(0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0));
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0);
        rst = 1'b1;
        cycle();
        drv(0, 0, 0, 0, 5'd5, 1'b1, 2'b00, 0);
        cycle();
        drv(0, 0, 5'd5, 0, 5'd6, 1'b0, 2'b00, 0);
        step("fwd_m", ex(0, 0, 0, 0, 2'b10, 2'b00, 4'd0, 4'd0));
        cycle();
        drv(0, 0, 5'd5, 5'd5, 5'd0, 1'b1, 2'b00, 0);
        step("fwd_w", ex(0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 4'd0));
        cycle();
        drv(0, 0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 0);
        step("fwd_x0", ex(0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0));
        cycle();
        cycle();
        drv(0, 0, 5'd7, 5'd7, 5'd0, 1'b0, 2'b00, 0);
        step("fwd_double", ex(0, 0, 0, 0, 2'b10, 2'b10, 4'd0, 4'd0));
        cycle();
        step("fwd_w_only", ex(0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 4'd0));
        drv(5'd0, 5'd3, 0, 0, 5'd3, 1'b1, 2'b01, 0);
        step("lw_stall", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd0, 4'd0));
        cycle();
        drv(5'd0, 5'd3, 0, 0, 5'd0, 1'b1, 2'b01, 0);
        step("lw_release", ex(0, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd0));
        cycle();
        drv(0, 0, 0, 5'd3, 5'd0, 1'b0, 2'b00, 0);
        step("lw_fwd_w", ex(0, 0, 0, 0, 2'b00, 2'b01, 4'd1, 4'd0));
        cycle();
        drv(5'd4, 0, 0, 0, 5'd4, 1'b1, 2'b01, 1'b1);
        step("branch", ex(0, 0, 1, 1, 2'b00, 2'b00, 4'd1, 4'd0));
        cycle();
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0);
        step("branch_cnt", ex(0, 0, 0, 0, 2'b00, 2'b00, 4'd1, 4'd1));
        drv(5'd3, 0, 0, 0, 5'd3, 1'b1, 2'b01, 0);
        for (int i = 0; i < 20; i++) cycle();
        step("sat", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd15, 4'd1));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        step("clr", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd0, 4'd0));
        cycle();
        step("clr_count", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd1, 4'd0));
        rst = 1'b0;
        step("rst_async", ex(0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 4'd0));
        rst = 1'b1;
        step("rst_release", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd0, 4'd0));
        cycle();
        step("post_rst_cnt", ex(1, 1, 0, 1, 2'b00, 2'b00, 4'd1, 4'd0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall enables for the IF/ID stages, the flush (CLR) controls for the IF/ID and ID/EX pipeline registers, and the EX-stage operand forwarding selects. It consumes the E-stage fields that the ID/EX register presents. It keeps its own registered shadow of the M- and W-stage destination registers, so it needs no taps on the EX/MEM or MEM/WB registers. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 16, width of each event counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_RS1_D  in  REG_ADDR_WIDTH  rs1 of the instruction in decode
- i_RS2_D  in  REG_ADDR_WIDTH  rs2 of the instruction in decode
- i_RS1_E  in  REG_ADDR_WIDTH  rs1 from the ID/EX register
- i_RS2_E  in  REG_ADDR_WIDTH  rs2 from the ID/EX register
- i_Rd_E  in  REG_ADDR_WIDTH  rd from the ID/EX register
- i_RegWrite_E  in  1  RegWrite from the ID/EX register
- i_ResultSrc_E  in  2  result select from the ID/EX register; 2'b01 = load
- i_PCSrc_E  in  1  taken branch or jump resolved in EX
- i_CntClr  in  1  synchronous clear of both counters
- o_Stall_F  out  1  hold PC
- o_Stall_D  out  1  hold the IF/ID register
- o_Flush_D  out  1  clear the IF/ID register
- o_Flush_E  out  1  clear the ID/EX register (its CLR input)
- o_ForwardA_E  out  2  SrcA select: 00 register file, 10 M-stage ALU result, 01 W-stage result
- o_ForwardB_E  out  2  SrcB select, same encoding
- o_StallCnt  out  CNT_WIDTH  number of load-use stall cycles
- o_FlushCnt  out  CNT_WIDTH  number of control-flush cycles

## Operation
- Shadow pipeline, updated every clock with no enable:
  - rd_m <= i_Rd_E; wr_m <= i_RegWrite_E
  - rd_w <= rd_m; wr_w <= wr_m
- The shadow is never stalled, because EX/MEM and MEM/WB never stall.
- A flushed ID/EX clears Rd to 0 but keeps its control bits. Every match therefore requires rd != 0; x0 is never a hazard source.
- Forwarding for operand A; operand B is identical using i_RS2_E:
  - If wr_m and rd_m != 0 and rd_m == i_RS1_E, select 10.
  - Otherwise, if wr_w and rd_w != 0 and rd_w == i_RS1_E, select 01.
  - Otherwise select 00.
  - M has priority over W when both match.
- Load-use detection:
  - lw_stall = (i_ResultSrc_E == 2'b01) & (i_Rd_E != 0) & ((i_Rd_E == i_RS1_D) | (i_Rd_E == i_RS2_D))
- Output equations:
  - o_Stall_F = o_Stall_D = lw_stall & ~i_PCSrc_E
  - o_Flush_D = i_PCSrc_E
  - o_Flush_E = lw_stall | i_PCSrc_E
  - A taken branch overrides a stall: the fetch must not hold when the PC redirects.
- No W→D forwarding. The register file writes on the falling clock edge, so a decode read in the same cycle returns the new value.
- Counters:
  - o_StallCnt increments when o_Stall_D = 1.
  - o_FlushCnt increments when o_Flush_D = 1.
  - Both saturate at all-ones and do not wrap.
  - i_CntClr zeroes both and has priority over increment. An event in the clear cycle is not counted.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the shadow registers, valid in the same cycle.
- A load-use hazard gives exactly one stall cycle. On the next edge the load moves to M, the bubble is in E, and lw_stall deasserts.
- A taken branch gives a 2-instruction penalty: D and E are flushed in the same cycle.
- Forwarding distance: a producer one instruction ahead forwards from M. A producer two instructions ahead forwards from W.
- Reset (rst low):
  - rd_m, wr_m, rd_w, wr_w, o_StallCnt and o_FlushCnt clear to 0 immediately.
  - o_Stall_F, o_Stall_D, o_Flush_D and o_Flush_E are forced to 0.
  - o_ForwardA_E and o_ForwardB_E are forced to 00.
- After reset release, the first edge loads the shadow from the E inputs. Reset asserted mid-stall drops the stall at once.
- Counter update has a 1-cycle latency: the value reflects events up to the previous edge.

## Test plan
- ALU-ALU back-to-back: add x5 in E, next cycle i_RS1_E=5 with wr_m=1 -> o_ForwardA_E=10; one cycle later with no newer writer -> 01; x0 as rd -> 00.
- Double match: rd_m=rd_w=7, i_RS2_E=7 -> o_ForwardB_E=10 (M wins).
- Load-use: i_ResultSrc_E=01, i_Rd_E=3, i_RS2_D=3 -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle; next cycle ForwardB_E=01; o_StallCnt +1.
- Taken branch with a coincident load-use pattern: i_PCSrc_E=1 -> Flush_D=Flush_E=1, Stall_F=Stall_D=0; o_FlushCnt +1, o_StallCnt unchanged.
- Counter saturation and clear: CNT_WIDTH=4, 20 stall cycles -> o_StallCnt=15; i_CntClr=1 during a stall -> 0 next cycle.
- Async reset mid-stall: drop rst between edges -> all outputs 0 and counters 0 immediately; release -> normal detection on the next cycle.
